cwalk_fsm: RTL and testbench



---
 rtl/cwalk_fsm.sv | 152 +++++++++++++++
 tb/tb_cwalk_fsm.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cwalk_fsm.sv
// Crosswalk sequencer: steps main-street lights and pedestrian lamps, driving an external
// 4-bit interval timer through pe/p/ce and advancing on its terminal count tc.
module cwalk_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       walk_btn,
  input  logic       tc,
  output logic       pe,
  output logic [3:0] p,
  output logic       ce,
  output logic       mg,
  output logic       my,
  output logic       mr,
  output logic       walk,
  output logic       dw,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_GRN   = 3'd1,
    S_YEL   = 3'd2,
    S_ARED  = 3'd3,
    S_WALK  = 3'd4,
    S_FLASH = 3'd5
  } state_t;

  // Presets are 16 - duration so the timer reaches tc on the Nth tick.
  localparam logic [3:0] P_GRN   = 4'd4;
  localparam logic [3:0] P_YEL   = 4'd13;
  localparam logic [3:0] P_ARED  = 4'd14;
  localparam logic [3:0] P_WALK  = 4'd10;
  localparam logic [3:0] P_FLASH = 4'd11;

  state_t state_q, state_d;
  logic   req_q;
  logic   green_done_q;
  logic   flash_q;

  always_comb begin
    state_d = state_q;
    pe      = 1'b0;
    p       = 4'd0;
    ce      = 1'b0;
    case (state_q)
      S_INIT: begin
        pe      = 1'b1;
        p       = P_GRN;
        state_d = S_GRN;
      end
      S_GRN: begin
        // Once green has run its minimum, the timer is parked until a request arrives.
        ce = tick & ~green_done_q;
        if ((tc | green_done_q) & req_q) begin
          pe      = 1'b1;
          p       = P_YEL;
          state_d = S_YEL;
        end
      end
      S_YEL: begin
        ce = tick;
        if (tc) begin
          pe      = 1'b1;
          p       = P_ARED;
          state_d = S_ARED;
        end
      end
      S_ARED: begin
        ce = tick;
        if (tc) begin
          pe      = 1'b1;
          p       = P_WALK;
          state_d = S_WALK;
        end
      end
      S_WALK: begin
        ce = tick;
        if (tc) begin
          pe      = 1'b1;
          p       = P_FLASH;
          state_d = S_FLASH;
        end
      end
      S_FLASH: begin
        ce = tick;
        if (tc) begin
          pe      = 1'b1;
          p       = P_GRN;
          state_d = S_GRN;
        end
      end
      default: begin
        pe      = 1'b1;
        p       = P_GRN;
        state_d = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_INIT;
      req_q        <= 1'b0;
      green_done_q <= 1'b0;
      flash_q      <= 1'b0;
    end else begin
      state_q <= state_d;

      // The request is consumed as the walk phase starts; presses during WALK are dropped.
      if (state_q == S_ARED && tc)
        req_q <= 1'b0;
      else if (walk_btn && state_q != S_WALK)
        req_q <= 1'b1;

      if (state_q != S_GRN || pe)
        green_done_q <= 1'b0;
      else if (tc && !req_q)
        green_done_q <= 1'b1;

      if (state_q == S_WALK && tc)
        flash_q <= 1'b1;
      else if (state_q == S_FLASH && tick)
        flash_q <= ~flash_q;
    end
  end

  always_comb begin
    mg   = 1'b0;
    my   = 1'b0;
    mr   = 1'b0;
    walk = 1'b0;
    dw   = 1'b1;
    case (state_q)
      S_GRN:   mg = 1'b1;
      S_YEL:   my = 1'b1;
      S_WALK: begin
        mr   = 1'b1;
        walk = 1'b1;
        dw   = 1'b0;
      end
      S_FLASH: begin
        mr = 1'b1;
        dw = flash_q;
      end
      default: mr = 1'b1;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_cwalk_fsm.sv
// Bench for cwalk_fsm: vector table, directed corner sequences and random stimulus
// checked against a countdown-based reference model; includes a model of the interval timer.
module tb_cwalk_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       walk_btn = 1'b0;
  logic       tc;
  logic       pe, ce, mg, my, mr, walk, dw;
  logic [3:0] p;
  logic [2:0] state;
  logic [3:0] tq = 4'd0;

  int n_tests = 0;
  int n_fail  = 0;

  cwalk_fsm dut (
    .clk(clk), .reset(reset), .tick(tick), .walk_btn(walk_btn), .tc(tc),
    .pe(pe), .p(p), .ce(ce), .mg(mg), .my(my), .mr(mr), .walk(walk), .dw(dw),
    .state(state)
  );

  always #5 clk = ~clk;

  // Loadable interval timer fed by the DUT.
  always @(posedge clk) begin
    if (pe) tq <= p;
    else if (ce) tq <= tq + 4'd1;
  end
  assign tc = (tq == 4'hF) && ce;

  // Reference model: phase number plus ticks remaining in the current interval.
  int         dur[6] = '{0, 12, 3, 2, 6, 5};
  logic [4:0] lamp_tab[6] = '{5'b00101, 5'b10001, 5'b01001, 5'b00101, 5'b00110, 5'b00100};
  int m_st = 0, m_left = 0;
  bit m_req = 0, m_gd = 0, m_fl = 0, m_valid = 0;
  bit e_ce, e_tc, e_pe;
  int e_dest, e_p;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_eval(input bit t);
    e_ce   = t && m_st >= 1 && m_st <= 5 && !(m_st == 1 && m_gd);
    e_tc   = e_ce && m_left == 1;
    e_dest = (m_st == 5) ? 1 : m_st + 1;
    if (m_st == 0)      e_pe = 1'b1;
    else if (m_st == 1) e_pe = (e_tc || m_gd) && m_req;
    else                e_pe = e_tc;
    e_p = e_pe ? 16 - dur[e_dest] : 0;
  endtask

  task automatic model_check();
    logic [4:0] lm;
    lm = lamp_tab[m_st];
    if (m_st == 5) lm[0] = m_fl;
    chk("state", int'(state), m_st);
    chk("lamps", int'({mg, my, mr, walk, dw}), int'(lm));
    chk("pe", int'(pe), int'(e_pe));
    chk("p", int'(p), e_p);
    chk("ce", int'(ce), int'(e_ce));
    if (m_st != 0) chk("timer", int'(tq), (16 - m_left) % 16);
  endtask

  task automatic model_update(input bit r, input bit t, input bit b);
    if (r) begin
      m_st = 0; m_req = 0; m_gd = 0; m_fl = 0; m_left = 0; m_valid = 1;
    end else begin
      if (m_st == 1 && e_pe) m_gd = 0;
      else if (m_st == 1 && e_tc && !m_req) m_gd = 1;
      if (m_st == 3 && e_pe) m_req = 0;
      else if (b && m_st != 4) m_req = 1;
      if (m_st == 4 && e_pe) m_fl = 1;
      else if (m_st == 5 && t) m_fl = !m_fl;
      if (e_pe) m_left = dur[e_dest];
      else if (e_ce) m_left = m_left - 1;
      if (e_pe) m_st = e_dest;
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked on the falling edge.
  task automatic drive(input bit r, input bit t, input bit b);
    reset = r; tick = t; walk_btn = b;
    #4;
    model_eval(t);
    if (m_valid) model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    model_update(reset, tick, walk_btn);
  endtask

  task automatic step(input bit r, input bit t, input bit b);
    drive(r, t, b);
    advance();
  endtask

  task automatic do_ticks(input int n);
    repeat (n) begin
      step(0, 1, 0);
      step(0, 0, 0);
    end
  endtask

  task automatic do_reset();
    step(1, 0, 0);
    step(1, 0, 0);
    chk("rst_state", int'(state), 0);
    step(0, 0, 0);
    chk("init_one_cycle", int'(state), 1);
  endtask

  // Counts ticks spent in state s, recording dw on each tick cycle.
  task automatic measure(input int s, output int n, output logic [7:0] dws);
    n = 0;
    dws = '0;
    while (int'(state) == s && n < 40) begin
      drive(0, 1, 0);
      dws = {dws[6:0], dw};
      advance();
      n++;
      if (int'(state) == s) step(0, 0, 0);
    end
    if (n >= 40) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout in state %0d", s);
    end
  endtask

  typedef struct {
    bit r; bit t; bit b;
    int st; bit pe; int p; bit ce;
  } vec_t;

  initial begin
    vec_t       vt[8];
    int         n;
    logic [7:0] dws;

    vt[0] = '{1, 0, 0, 0, 1, 4, 0};
    vt[1] = '{0, 0, 0, 0, 1, 4, 0};
    vt[2] = '{0, 1, 0, 1, 0, 0, 1};
    vt[3] = '{0, 0, 1, 1, 0, 0, 0};
    vt[4] = '{0, 1, 0, 1, 0, 0, 1};
    vt[5] = '{1, 1, 0, 1, 0, 0, 1};
    vt[6] = '{0, 1, 0, 0, 1, 4, 0};
    vt[7] = '{0, 0, 0, 1, 0, 0, 0};

    step(1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].r, vt[i].t, vt[i].b);
      chk("vec_state", int'(state), vt[i].st);
      chk("vec_pe", int'(pe), int'(vt[i].pe));
      chk("vec_p", int'(p), vt[i].p);
      chk("vec_ce", int'(ce), int'(vt[i].ce));
      advance();
    end

    // No press: green parks after its minimum.
    do_reset();
    do_ticks(40);
    drive(0, 1, 0);
    chk("park_ce", int'(ce), 0);
    chk("park_mg", int'(mg), 1);
    chk("park_state", int'(state), 1);
    advance();

    // Late press with green already done: two edges to YEL.
    step(0, 0, 1);
    chk("late_edge1", int'(state), 1);
    drive(0, 0, 0);
    chk("late_pe", int'(pe), 1);
    chk("late_p", int'(p), 13);
    advance();
    chk("late_yel", int'(state), 2);
    measure(2, n, dws);  chk("yel_ticks", n, 3);
    measure(3, n, dws);  chk("ared_ticks", n, 2);
    chk("walk_lamp", int'(walk), 1);
    chk("walk_dw", int'(dw), 0);
    measure(4, n, dws);  chk("walk_ticks", n, 6);
    measure(5, n, dws);  chk("flash_ticks", n, 5);
    chk("flash_dw_seq", int'(dws[4:0]), 21);
    chk("flash_to_grn", int'(state), 1);
    do_ticks(16);
    drive(0, 1, 0);
    chk("noreq_ce", int'(ce), 0);
    chk("noreq_state", int'(state), 1);
    advance();

    // Early press at tick 3; exit tick also carries tick, so pe must win.
    do_reset();
    do_ticks(2);
    step(0, 1, 1);
    step(0, 0, 0);
    measure(1, n, dws);  chk("early_grn_ticks", n, 9);
    chk("simul_timer", int'(tq), 13);
    measure(2, n, dws);  chk("yel2_ticks", n, 3);
    measure(3, n, dws);  chk("ared2_ticks", n, 2);
    step(0, 0, 1);
    measure(4, n, dws);  chk("walk2_ticks", n, 6);
    measure(5, n, dws);  chk("flash2_ticks", n, 5);
    do_ticks(12);
    drive(0, 1, 0);
    chk("walkpress_ignored", int'(ce), 0);
    chk("walkpress_state", int'(state), 1);
    advance();

    // Press during FLASH is carried into the next green.
    step(0, 0, 1);
    step(0, 0, 0);
    measure(2, n, dws);
    measure(3, n, dws);
    measure(4, n, dws);
    step(0, 0, 1);
    measure(5, n, dws);
    measure(1, n, dws);  chk("flashpress_grn", n, 12);

    // Reset at tick 3 of WALK.
    measure(2, n, dws);
    measure(3, n, dws);
    do_ticks(2);
    drive(1, 1, 0);
    advance();
    chk("rstwalk_state", int'(state), 0);
    chk("rstwalk_walk", int'(walk), 0);
    chk("rstwalk_dw", int'(dw), 1);
    chk("rstwalk_mr", int'(mr), 1);
    drive(0, 0, 0);
    chk("rstwalk_pe", int'(pe), 1);
    chk("rstwalk_p", int'(p), 4);
    advance();
    do_ticks(14);
    drive(0, 1, 0);
    chk("rstwalk_noreq", int'(ce), 0);
    advance();

    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 499) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
